// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding and the
// default data-memory depth, which the pipeline top reuses.
// Latency: n/a (definitions only). Backpressure: n/a.
package dmem_arb_pkg;

   // Number of words in the data memory; addresses at or above this are errors.
   localparam int DMEM_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: combinational two-way round-robin grant.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies the grants with its own state.
// Ports:
//   valid0_i, valid1_i : request present on port 0 / port 1
//   last_i             : port that won the previous acceptance
//   grant0_o, grant1_o : one-hot (or zero) grant
//   winner_o           : index of the granted port (meaningful when a grant is set)
module rr_arbiter2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_i,
   output logic grant0_o,
   output logic grant1_o,
   output logic winner_o
);

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant0_o = valid0_i & (~valid1_i | last_i);
      grant1_o = valid1_i & (~valid0_i | ~last_i);
      winner_o = grant1_o;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: shares the data memory's single async read/write port between the
//          MEM stage (port 0) and the debug/loader port (port 1).
// Latency: accept -> rsp_valid in 2 cycles; one access per 3 cycles at best.
// Backpressure: only the granted port sees ready, and only in IDLE; others wait.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   pN_req_*                   : valid/ready request (we, word addr, wdata)
//   pN_rsp_*                   : one-cycle registered response (rdata, err)
//   mem_*                      : registered memory controls, mem_read_data is async
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = DMEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   output logic              p0_rsp_err,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic              p1_rsp_err,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   arb_state_e state_q, state_d;

   // Round-robin pointer; resets to 1 so port 0 wins the first tie.
   logic last_q, last_d;

   // Latched request. addr/wdata double as mem_address/mem_write_data so the
   // memory sees them change only at acceptance and hold otherwise.
   logic              we_q, we_d;
   logic              winner_q, winner_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic mem_re_q, mem_re_d;
   logic mem_we_q, mem_we_d;

   logic [1:0]        rsp_vld_q, rsp_vld_d;
   logic [1:0]        rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

   logic              grant0, grant1, winner;
   logic              accept, issue;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_in_range;
   logic [DATA_W-1:0] rd_capture;

   rr_arbiter2 u_rr (
      .valid0_i (p0_req_valid),
      .valid1_i (p1_req_valid),
      .last_i   (last_q),
      .grant0_o (grant0),
      .grant1_o (grant1),
      .winner_o (winner)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      p0_req_ready = (state_q == IDLE) & grant0;
      p1_req_ready = (state_q == IDLE) & grant1;
      accept       = p0_req_ready | p1_req_ready;
      issue        = (state_q == ISSUE);
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      req_we       = winner ? p1_req_we    : p0_req_we;
      req_addr     = winner ? p1_req_addr  : p0_req_addr;
      req_wdata    = winner ? p1_req_wdata : p0_req_wdata;
      req_in_range = (req_addr < DEPTH_A);

      last_d   = accept ? winner       : last_q;
      we_d     = accept ? req_we       : we_q;
      winner_d = accept ? winner       : winner_q;
      err_d    = accept ? ~req_in_range : err_q;
      addr_d   = accept ? req_addr     : addr_q;
      wdata_d  = accept ? req_wdata    : wdata_q;

      // Enables rise with the address at acceptance and fall one edge later,
      // so they are high for the ISSUE cycle only.
      mem_re_d = accept & req_in_range & ~req_we;
      mem_we_d = accept & req_in_range &  req_we;

      // Only in-range reads return memory data; writes and errors return 0.
      rd_capture = (~we_q & ~err_q) ? mem_read_data : '0;

      rsp_vld_d[0] = issue & ~winner_q;
      rsp_vld_d[1] = issue &  winner_q;
      rsp_err_d[0] = rsp_vld_d[0] & err_q;
      rsp_err_d[1] = rsp_vld_d[1] & err_q;
      rsp0_rdata_d = rsp_vld_d[0] ? rd_capture : '0;
      rsp1_rdata_d = rsp_vld_d[1] ? rd_capture : '0;
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q       <= 1'b1;
         we_q         <= 1'b0;
         winner_q     <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         rsp_vld_q    <= '0;
         rsp_err_q    <= '0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         last_q       <= last_d;
         we_q         <= we_d;
         winner_q     <= winner_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_err_q    <= rsp_err_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   always_comb begin
      mem_read_enable  = mem_re_q;
      mem_write_enable = mem_we_q;
      mem_address      = addr_q;
      mem_write_data   = wdata_q;
      p0_rsp_valid     = rsp_vld_q[0];
      p1_rsp_valid     = rsp_vld_q[1];
      p0_rsp_err       = rsp_err_q[0];
      p1_rsp_err       = rsp_err_q[1];
      p0_rsp_rdata     = rsp0_rdata_q;
      p1_rsp_rdata     = rsp1_rdata_q;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the 8×32-bit data memory. It shares the memory's single asynchronous read/write port between the pipeline MEM stage (port 0) and the debug/loader port (port 1). It uses a valid/ready request handshake, round-robin grant and a registered one-cycle response pulse. It owns every memory control signal, so enables are only ever driven from registers, held for exactly one cycle.

## Interface
- DATA_W, 32, data width of requests, responses and memory port
- ADDR_W, 32, word-address width (memory indexes words directly)
- DEPTH, 8, number of valid memory words; addresses ≥ DEPTH are errors

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- pN_req_valid  in  1  request present (N = 0, 1)
- pN_req_ready  out  1  request accepted this cycle when valid & ready
- pN_req_we  in  1  1 = write, 0 = read
- pN_req_addr  in  ADDR_W  word address
- pN_req_wdata  in  DATA_W  write data
- pN_rsp_valid  out  1  one-cycle response pulse
- pN_rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- pN_rsp_err  out  1  address out of range, qualified by pN_rsp_valid
- mem_read_enable  out  1  memory read enable
- mem_write_enable  out  1  memory write enable
- mem_address  out  ADDR_W  memory word address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  memory read data (combinational from enable/address)

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Grant is computed combinationally from the two valids and the round-robin pointer `last`.
  - Only the granted port sees ready = 1. The other port, and every port in other states, sees ready = 0.
  - On valid & ready, latch we/addr/wdata and the winner id, then go to ISSUE.
- **Round-robin**
  - If both ports are valid, grant the port ≠ `last`.
  - If only one port is valid, grant it.
  - `last` updates to the winner on acceptance.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- **ISSUE** (exactly one cycle)
  - mem_address and mem_write_data are driven from the latched registers.
  - For an in-range address, assert mem_read_enable (read) or mem_write_enable (write) for this cycle only.
  - For an out-of-range address, assert no enable and set err.
  - At the closing edge, capture mem_read_data into the response register for in-range reads, otherwise capture 0.
  - Go to RESP.
- **RESP**
  - Assert winner's rsp_valid for one cycle with rdata/err.
  - The other port's rsp outputs stay 0.
  - Next state is IDLE.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal and issues nothing.
- Writes also produce a response pulse, with rdata = 0 and err = 0.

## Timing
- Acceptance at edge E: ISSUE occupies cycle E..E+1, and rsp_valid is high in cycle E+1..E+2.
- Request-to-response latency is 2 cycles. Peak throughput is 1 access per 3 cycles.
- All outputs except pN_req_ready are registered.
  - mem_address and mem_write_data hold their last values outside ISSUE.
  - Both enables are 0 outside ISSUE.
  - Write enable never overlaps an address change.
- Reset values: state IDLE, all enables 0, mem_address 0, mem_write_data 0, all rsp_valid/rsp_err 0, rsp_rdata 0, `last` = 1.
- Reset mid-operation (ISSUE or RESP) aborts immediately: enables drop asynchronously and no response is produced. A write in flight may or may not have landed.
- A new request arriving while the FSM is in ISSUE or RESP waits; ready stays 0.
- Boundary address DEPTH−1 (7) is valid; DEPTH (8) and above give err = 1.

## Structure
- Shared package/include `dmem_arb_pkg`: state encoding (IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2) and the DEPTH default. The pipeline top reuses the same constant.
- Sub-module `rr_arbiter2`: combinational two-way round-robin grant from (valid0, valid1, last), producing grant0, grant1 and winner.
- FSM, request latch and response registers live in `dmem_arbiter`.

## Test plan
- Port 0 reads addr 1 alone → ready in accepting cycle; 2 cycles later p0_rsp_valid = 1, rdata = 0x08070605, err = 0; mem_read_enable high for exactly one cycle.
- Port 1 writes 0xDEADBEEF to addr 3, then port 0 reads addr 3 → write ack with rdata 0; read returns 0xDEADBEEF.
- Both ports continuously valid, reading addr 0 and addr 2 → grants alternate 0, 1, 0, 1, starting with port 0 after reset; responses 0x04030201 and 0x03030003 alternate, one every 3 cycles.
- Port 0 reads addr 8, then writes addr 0xFFFFFFFF → err = 1, rdata = 0, no mem enable asserted in either ISSUE cycle; memory contents unchanged.
- Port 1 write accepted, reset pulsed during ISSUE → enables drop with reset, no rsp_valid; after release all outputs are at reset values and the next tie is granted to port 0.
- Port 0 raises valid while port 1's transaction is in RESP → p0_req_ready stays 0 until IDLE, then the request is accepted on the next edge.
